// File: rtl/fpu_add_norm_round.sv
// fpu_add_norm_round: post-addition normalize, round-to-nearest-even and pack stage of fpu_add.
// Two-stage valid/ready pipeline (normalize, then round/pack) with full throughput.
// Optional macro FPU_ADD_NORM_FLAGS_EN adds out_flags = {overflow, underflow, inexact}.
module fpu_add_norm_round #(
  parameter int unsigned MANT_W = 24,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned SUM_W  = MANT_W + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [SUM_W-1:0]        in_sum,
  input  logic                    in_special,
  input  logic [EXP_W+MANT_W-1:0] in_special_res,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef FPU_ADD_NORM_FLAGS_EN
  output logic [2:0]              out_flags,
`endif
  output logic [EXP_W+MANT_W-1:0] out_result
);

  localparam int unsigned ResW   = EXP_W + MANT_W;
  localparam int unsigned ExpIW  = EXP_W + 2;
  localparam int unsigned SigW   = SUM_W - 1;
  localparam int unsigned MantRW = MANT_W + 1;
  localparam int unsigned LzW    = $clog2(SUM_W + 1);

  localparam logic signed [ExpIW-1:0] ExpOne = ExpIW'(1);
  localparam logic signed [ExpIW-1:0] ExpInf = ExpIW'((1 << EXP_W) - 1);

  // Handshake
  logic s1_ready;
  logic s2_ready;

  // Stage 1 state
  logic                    s1_valid_q;
  logic                    s1_special_q;
  logic [ResW-1:0]         s1_spec_res_q;
  logic                    s1_sign_q;
  logic                    s1_zero_q;
  logic signed [ExpIW-1:0] s1_exp_q;
  logic [SigW-1:0]         s1_sig_q;

  // Stage 1 next-state
  logic                    s1_valid_d;
  logic                    s1_sign_d;
  logic                    s1_zero_d;
  logic signed [ExpIW-1:0] s1_exp_d;
  logic [SigW-1:0]         s1_sig_d;

  // Stage 2 state / next-state
  logic            s2_valid_q;
  logic            s2_valid_d;
  logic [ResW-1:0] s2_result_q;
  logic [ResW-1:0] s2_result_d;

`ifdef FPU_ADD_NORM_FLAGS_EN
  logic       s1_uf_q;
  logic       s1_uf_d;
  logic [2:0] s2_flags_q;
  logic [2:0] s2_flags_d;
`endif

  // Normalize datapath
  logic [LzW-1:0]          lz;
  logic [LzW-1:0]          lz_m1;
  logic signed [ExpIW-1:0] exp_in;
  logic signed [ExpIW-1:0] norm_exp;
  logic                    sum_zero;
  logic                    flush;

  // Round datapath
  logic [MANT_W-1:0]       mant;
  logic                    g_bit;
  logic                    r_bit;
  logic                    s_bit;
  logic                    round_up;
  logic [MantRW-1:0]       mant_r;
  logic [MANT_W-2:0]       frac;
  logic signed [ExpIW-1:0] exp_f;
  logic                    ovf;

  // A stage loads when it is empty or its contents move on this cycle.
  always_comb begin
    s2_ready   = !s2_valid_q || out_ready;
    s1_ready   = !s1_valid_q || s2_ready;
    in_ready   = s1_ready;
    s1_valid_d = s1_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
  end

  // Leading-zero count of the raw sum; the highest set bit wins, all-zero gives SUM_W.
  always_comb begin
    lz = LzW'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (in_sum[i]) begin
        lz = LzW'(SUM_W - 1 - i);
      end
    end
  end

  // Stage 1: bring the hidden bit to position SUM_W-2 and adjust the exponent.
  always_comb begin
    lz_m1    = lz - LzW'(1);
    exp_in   = $signed({2'b00, in_exp});
    sum_zero = (in_sum == '0);
    if (lz == '0) begin
      // Carry out: the dropped bit folds into sticky.
      s1_sig_d = {in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
      norm_exp = exp_in + ExpOne;
    end else begin
      s1_sig_d = SigW'(in_sum << lz_m1);
      norm_exp = exp_in - $signed({{(ExpIW - LzW){1'b0}}, lz_m1});
    end
    // No subnormals: any non-positive exponent flushes to a signed zero.
    flush     = !sum_zero && (norm_exp[ExpIW-1] || (norm_exp == '0));
    s1_exp_d  = norm_exp;
    s1_zero_d = sum_zero || flush;
    // Exact cancellation yields +0 under round-to-nearest-even.
    s1_sign_d = sum_zero ? 1'b0 : in_sign;
`ifdef FPU_ADD_NORM_FLAGS_EN
    s1_uf_d   = flush;
`endif
  end

  // Stage 2: round to nearest even, renormalize on significand overflow, pack.
  always_comb begin
    mant     = s1_sig_q[SigW-1:3];
    g_bit    = s1_sig_q[2];
    r_bit    = s1_sig_q[1];
    s_bit    = s1_sig_q[0];
    round_up = g_bit && (r_bit || s_bit || mant[0]);
    mant_r   = {1'b0, mant} + MantRW'(round_up);
    if (mant_r[MANT_W]) begin
      frac  = mant_r[MANT_W-1:1];
      exp_f = s1_exp_q + ExpOne;
    end else begin
      frac  = mant_r[MANT_W-2:0];
      exp_f = s1_exp_q;
    end
    ovf = (exp_f >= ExpInf);

    s2_result_d = {s1_sign_q, exp_f[EXP_W-1:0], frac};
`ifdef FPU_ADD_NORM_FLAGS_EN
    s2_flags_d  = {1'b0, 1'b0, g_bit | r_bit | s_bit};
`endif
    if (s1_special_q) begin
      s2_result_d = s1_spec_res_q;
`ifdef FPU_ADD_NORM_FLAGS_EN
      s2_flags_d  = 3'b000;
`endif
    end else if (s1_zero_q) begin
      s2_result_d = {s1_sign_q, {(ResW - 1){1'b0}}};
`ifdef FPU_ADD_NORM_FLAGS_EN
      s2_flags_d  = {1'b0, s1_uf_q, s1_uf_q};
`endif
    end else if (ovf) begin
      s2_result_d = {s1_sign_q, {EXP_W{1'b1}}, {(MANT_W - 1){1'b0}}};
`ifdef FPU_ADD_NORM_FLAGS_EN
      s2_flags_d  = 3'b101;
`endif
    end
  end

  // Stage 1 register: data captured only on an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_special_q  <= 1'b0;
      s1_spec_res_q <= '0;
      s1_sign_q     <= 1'b0;
      s1_zero_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_sig_q      <= '0;
`ifdef FPU_ADD_NORM_FLAGS_EN
      s1_uf_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_ready && in_valid) begin
        s1_special_q  <= in_special;
        s1_spec_res_q <= in_special_res;
        s1_sign_q     <= s1_sign_d;
        s1_zero_q     <= s1_zero_d;
        s1_exp_q      <= s1_exp_d;
        s1_sig_q      <= s1_sig_d;
`ifdef FPU_ADD_NORM_FLAGS_EN
        s1_uf_q       <= s1_uf_d;
`endif
      end
    end
  end

  // Stage 2 register: result held while the downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
`ifdef FPU_ADD_NORM_FLAGS_EN
      s2_flags_q  <= 3'b000;
`endif
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_ready && s1_valid_q) begin
        s2_result_q <= s2_result_d;
`ifdef FPU_ADD_NORM_FLAGS_EN
        s2_flags_q  <= s2_flags_d;
`endif
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
`ifdef FPU_ADD_NORM_FLAGS_EN
  assign out_flags  = s2_flags_q;
`endif

endmodule

// File: tb/tb_fpu_add_norm_round.sv
// Scoreboard bench for fpu_add_norm_round: driver pushes expected results, monitor pops
// and compares on each output handshake. Build with FPU_ADD_NORM_FLAGS_EN to check flags.
module tb_fpu_add_norm_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_sum;
  logic        in_special;
  logic [31:0] in_special_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FPU_ADD_NORM_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  typedef struct packed {
    logic        sg;
    logic [7:0]  ex;
    logic [27:0] sm;
    logic        sp;
    logic [31:0] spr;
    logic [31:0] er;
    logic [2:0]  ef;
  } vec_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          n_out    = 0;
  logic        hold_v   = 1'b0;
  logic [31:0] hold_res = '0;

  fpu_add_norm_round dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_sum         (in_sum),
    .in_special     (in_special),
    .in_special_res (in_special_res),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
`ifdef FPU_ADD_NORM_FLAGS_EN
    .out_flags      (out_flags),
`endif
    .out_result     (out_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input logic sg, input logic [7:0] ex, input logic [27:0] sm,
                              input logic [31:0] er, input logic [2:0] ef);
    vec_t v;
    v = '{sg: sg, ex: ex, sm: sm, sp: 1'b0, spr: 32'h0, er: er, ef: ef};
    return v;
  endfunction

  // Special passthrough with deliberately misleading sum/exponent.
  function automatic vec_t mk_special(input logic [31:0] res);
    vec_t v;
    v = '{sg: 1'b1, ex: 8'hFF, sm: 28'h8000000, sp: 1'b1, spr: res, er: res, ef: 3'b000};
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input vec_t v);
    logic acc = 1'b0;
    int   n   = 0;
    in_valid       = 1'b1;
    in_sign        = v.sg;
    in_exp         = v.ex;
    in_sum         = v.sm;
    in_special     = v.sp;
    in_special_res = v.spr;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) begin
      sb.push_back('{res: v.er, flags: v.ef});
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 64 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // After send returns: output absent one cycle after acceptance, present the next.
  task automatic lat_check(input string name);
    @(negedge clk);
    chk({name, "_c1_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({name, "_c2_valid"}, 32'(out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares on handshake, and checks output stability while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("held_valid", 32'(out_valid), 1);
          chk("held_result", out_result, hold_res);
          hold_v = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got %h expected no output", out_result);
          end else begin
            e = sb.pop_front();
            chk($sformatf("result#%0d", n_out), out_result, e.res);
`ifdef FPU_ADD_NORM_FLAGS_EN
            chk($sformatf("flags#%0d", n_out), 32'(out_flags), 32'(e.flags));
`endif
            n_out++;
          end
        end else if (out_valid) begin
          hold_v   = 1'b1;
          hold_res = out_result;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[$];
    vec_t bp[$];

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_sign        = 1'b0;
    in_exp         = '0;
    in_sum         = '0;
    in_special     = 1'b0;
    in_special_res = '0;
    out_ready      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 1.0 with latency check
    send(mk(1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000));
    lat_check("lat_first");

    v.push_back(mk(1'b0, 8'd127, 28'h1000000, 32'h3E800000, 3'b000)); // cancellation, lz=3
    v.push_back(mk(1'b1, 8'd127, 28'h0000000, 32'h00000000, 3'b000)); // exact zero -> +0
    v.push_back(mk(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001)); // tie, even stays
    v.push_back(mk(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001)); // tie, odd rounds up
    v.push_back(mk(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b101)); // normalize overflow
    v.push_back(mk(1'b1, 8'd1,   28'h1000000, 32'h80000000, 3'b011)); // flush, exp -1
    v.push_back(mk(1'b0, 8'd1,   28'h2000000, 32'h00000000, 3'b011)); // flush, exp 0
    v.push_back(mk(1'b0, 8'd2,   28'h2000000, 32'h00800000, 3'b000)); // smallest normal
    v.push_back(mk(1'b0, 8'd127, 28'h8000003, 32'h40000000, 3'b001)); // carry, lost bit sticky
    v.push_back(mk(1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b001)); // round carries out
    v.push_back(mk(1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101)); // rounding overflow
    v.push_back(mk(1'b1, 8'd127, 28'h4000000, 32'hBF800000, 3'b000)); // -1.0
    v.push_back(mk(1'b0, 8'd127, 28'h4000005, 32'h3F800001, 3'b001)); // G and S round up
    v.push_back(mk(1'b0, 8'd127, 28'h0000008, 32'h34000000, 3'b000)); // lz=24
    v.push_back(mk_special(32'h7FC00000));
    v.push_back(mk(1'b1, 8'd253, 28'h8000000, 32'hFF000000, 3'b000)); // largest finite exp
    foreach (v[i]) send(v[i]);
    wait_drain("drain_directed");

    // Backpressure: out_ready low for 4 cycles while 5 inputs stream in
    bp.push_back(mk(1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000));
    bp.push_back(mk(1'b0, 8'd127, 28'h1000000, 32'h3E800000, 3'b000));
    bp.push_back(mk_special(32'h7FC00000));
    bp.push_back(mk(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001));
    bp.push_back(mk(1'b0, 8'd127, 28'h4000005, 32'h3F800001, 3'b001));
    out_ready = 1'b0;
    fork
      begin
        foreach (bp[i]) send(bp[i]);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_backpressure");

    // Reset with both stages full
    out_ready = 1'b0;
    send(mk(1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000));
    send(mk(1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(in_ready), 1);
    chk("postrst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    send(mk(1'b0, 8'd127, 28'h4000000, 32'h3F800000, 3'b000));
    lat_check("lat_postrst");
    wait_drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_add_norm_round.md
Name: fpu_add_norm_round

Overview:
Post-addition normalize-and-round stage of the fpu_add datapath. It sits directly downstream of the aligned mantissa adder and consumes the raw sum, exponent and sign. It counts leading zeros with the fpu_add leading-zero detector, normalizes, rounds to nearest-even and packs an IEEE-754 single-precision result. The block is a 2-stage valid/ready pipeline with full throughput and backpressure.

Parameters:
MANT_W, 24, significand width including hidden bit
EXP_W, 8, biased exponent width
SUM_W, MANT_W+4, raw sum width: {carry, hidden, fraction[MANT_W-2:0], guard, round, sticky}

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  upstream sum valid
in_ready  out  1  stage can accept
in_sign  in  1  result sign from adder
in_exp  in  EXP_W  biased exponent of larger operand
in_sum  in  SUM_W  raw magnitude sum; bit SUM_W-2 is hidden position
in_special  in  1  upstream resolved NaN/Inf/zero-operand case
in_special_res  in  EXP_W+MANT_W  packed result for the special case
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  EXP_W+MANT_W  packed {sign, exp, frac}

Behaviour:
- Reset: all stage valids 0, out_valid=0, out_result=0, in_ready=1. A reset during operation discards in-flight data with no output.
- Latency: 2 cycles, in_valid&in_ready to out_valid, when not stalled. Throughput 1 per cycle.
- Handshake: a transfer occurs on valid&ready. Each stage register loads when it is empty or its downstream is advancing. in_ready = !s1_valid | (s2 advancing). out_result and out_valid are held stable while out_valid & !out_ready.
- Stage 1 (normalize):
  - lz = leading-zero count of in_sum.
  - Exponent math is done signed at EXP_W+2 bits.
  - in_sum==0: zero result, sign forced 0 (RNE exact cancellation).
  - lz==0 (carry set): shift right 1, OR the lost bit into sticky, exp+1.
  - lz>=1: shift left lz-1, exp-(lz-1).
  - Normalized exp <= 0: flush to signed zero (no subnormals).
- Stage 2 (round/pack):
  - RNE: round_up = G & (R | S | LSB).
  - Significand increments; on overflow to 2^MANT_W, shift right 1 and exp+1.
  - Final exp >= 2^EXP_W-1: result is Inf with the same sign, frac 0.
  - Pack {sign, exp[EXP_W-1:0], frac[MANT_W-2:0]}.
- in_special=1: in_special_res passes through both stages unmodified and in order; in_sum and in_exp are ignored.

Optional Feature:
- Macro: FPU_ADD_NORM_FLAGS_EN.
- Defined: adds port out_flags out 3 = {overflow, underflow, inexact}, pipelined and aligned with out_result.
  - inexact = G|R|S after normalize, or any flush/overflow.
  - underflow = flush to zero from a nonzero sum.
  - overflow = Inf produced by rounding or normalizing.
  - All flags are 0 for special passthrough. Flags reset to 0.
- Undefined: no port and no flag logic; all other behaviour is identical.

Test Plan:
- 1.0+1.0: in_exp=127, in_sum=28'h8000000, sign 0 -> out_result=32'h40000000 two cycles later.
- Cancellation: in_exp=127, in_sum=28'h1000000 -> lz=3, out_result=32'h3E800000. in_sum=0 with sign 1 -> 32'h00000000.
- Tie-to-even: in_exp=127, in_sum=28'h4000004 -> 32'h3F800000 (no round up). in_sum=28'h400000C -> 32'h3F800002. Flags build: inexact=1 on both.
- Overflow: in_exp=254, in_sum=28'h8000000 -> 32'h7F800000. Flags build: overflow=1, inexact=1.
- Backpressure: stream 4 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, out_result stays stable, all 4 results emerge in order with none lost or duplicated. in_special with 32'h7FC00000 is interleaved and passes through unchanged.
- Reset: assert rst_n=0 mid-stream with both stages full -> out_valid=0 and out_result=0 immediately. After release, in_ready=1 and the first new input produces a correct result 2 cycles later.
